// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types, constants and grant helper for the write-back port arbiter
package wb_arb_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } wb_state_e;

  localparam logic GRANT_REQ0 = 1'b0;
  localparam logic GRANT_REQ1 = 1'b1;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_CNT_W  = 16;

  // A lone requester always wins; on a tie the one not served last wins.
  function automatic logic rr_grant(input logic v0, input logic v1, input logic last);
    if (v0 && v1) begin
      return ~last;
    end else if (v1) begin
      return GRANT_REQ1;
    end else begin
      return GRANT_REQ0;
    end
  endfunction

endpackage

// File: rtl/wb_mux2.sv
// rtl/wb_mux2.sv - N-bit 2:1 mux assembled from per-bit 1-bit mux cells
module wb_mux2 #(
  parameter int N = 8
) (
  input  logic         i_sel,
  input  logic [N-1:0] i_iftrue,
  input  logic [N-1:0] i_iffalse,
  output logic [N-1:0] o_out
);

  for (genvar g = 0; g < N; g++) begin : g_bit
    assign o_out[g] = i_sel ? i_iftrue[g] : i_iffalse[g];
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - round-robin arbiter sharing the register-file write-back port
// Optional conflict counter enabled by defining WB_ARB_STATS_EN.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0_valid,
  input  logic [ADDR_W-1:0] i_req0_addr,
  input  logic [DATA_W-1:0] i_req0_data,
  output logic              o_req0_ready,
  input  logic              i_req1_valid,
  input  logic [ADDR_W-1:0] i_req1_addr,
  input  logic [DATA_W-1:0] i_req1_data,
  output logic              o_req1_ready,
  output logic              o_wb_en,
  output logic [ADDR_W-1:0] o_wb_addr,
  output logic [DATA_W-1:0] o_wb_data,
  output logic              o_wb_sel,
  input  logic              i_wb_ready,
  output logic [CNT_W-1:0]  o_conflict_cnt
);

  localparam int MUX_W = ADDR_W + DATA_W;

  wb_state_e         r_state;
  logic              r_last;
  logic [ADDR_W-1:0] r_wb_addr;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_wb_sel;

  logic              w_accept;
  logic              w_grant;
  logic              w_xfer;
  logic [MUX_W-1:0]  w_mux_out;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;

  assign w_accept = (r_state == ST_EMPTY) | i_wb_ready;
  assign w_grant  = rr_grant(i_req0_valid, i_req1_valid, r_last);

  // Gated by reset so nothing is handed out while the arbiter is held in reset.
  assign o_req0_ready = i_rst_n & w_accept & i_req0_valid & (w_grant == GRANT_REQ0);
  assign o_req1_ready = i_rst_n & w_accept & i_req1_valid & (w_grant == GRANT_REQ1);
  assign w_xfer       = o_req0_ready | o_req1_ready;

  wb_mux2 #(.N(MUX_W)) u_wb_mux (
    .i_sel     (w_grant),
    .i_iftrue  ({i_req1_addr, i_req1_data}),
    .i_iffalse ({i_req0_addr, i_req0_data}),
    .o_out     (w_mux_out)
  );

  assign {w_addr, w_data} = w_mux_out;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_EMPTY;
      r_last    <= GRANT_REQ1;
      r_wb_addr <= '0;
      r_wb_data <= '0;
      r_wb_sel  <= GRANT_REQ0;
    end else if (w_xfer) begin
      r_last <= w_grant;
      // Writes to register 0 are consumed but never presented to the register file.
      if (w_addr != '0) begin
        r_state   <= ST_FULL;
        r_wb_addr <= w_addr;
        r_wb_data <= w_data;
        r_wb_sel  <= w_grant;
      end else begin
        r_state <= ST_EMPTY;
      end
    end else if ((r_state == ST_FULL) && i_wb_ready) begin
      r_state <= ST_EMPTY;
    end
  end

  assign o_wb_en   = (r_state == ST_FULL);
  assign o_wb_addr = r_wb_addr;
  assign o_wb_data = r_wb_data;
  assign o_wb_sel  = r_wb_sel;

`ifdef WB_ARB_STATS_EN
  logic [CNT_W-1:0] r_conflict_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_conflict_cnt <= '0;
    end else if (i_req0_valid && i_req1_valid && w_accept && (r_conflict_cnt != '1)) begin
      r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end
  end

  assign o_conflict_cnt = r_conflict_cnt;
`else
  assign o_conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;
`ifdef WB_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req0_valid = 1'b0;
  logic [ADDR_W-1:0] req0_addr = '0;
  logic [DATA_W-1:0] req0_data = '0;
  logic              req0_ready;
  logic              req1_valid = 1'b0;
  logic [ADDR_W-1:0] req1_addr = '0;
  logic [DATA_W-1:0] req1_data = '0;
  logic              req1_ready;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_sel;
  logic              wb_ready = 1'b0;
  logic [CNT_W-1:0]  conflict_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_req0_valid   (req0_valid),
    .i_req0_addr    (req0_addr),
    .i_req0_data    (req0_data),
    .o_req0_ready   (req0_ready),
    .i_req1_valid   (req1_valid),
    .i_req1_addr    (req1_addr),
    .i_req1_data    (req1_data),
    .o_req1_ready   (req1_ready),
    .o_wb_en        (wb_en),
    .o_wb_addr      (wb_addr),
    .o_wb_data      (wb_data),
    .o_wb_sel       (wb_sel),
    .i_wb_ready     (wb_ready),
    .o_conflict_cnt (conflict_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] exp_cnt(input int v);
    if (!STATS) return 64'd0;
    return (v > 15) ? 64'd15 : 64'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_wb_en", wb_en, 0);
    check("rst_wb_addr", wb_addr, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_wb_sel", wb_sel, 0);
    check("rst_cnt", conflict_cnt, 0);
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);

    // 1: single requester 0 write
    wb_ready = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hDEADBEEF;
    #1;
    check("t1_ready0", req0_ready, 1);
    check("t1_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    #1;
    check("t1_wb_en", wb_en, 1);
    check("t1_wb_addr", wb_addr, 3);
    check("t1_wb_data", wb_data, 32'hDEADBEEF);
    check("t1_wb_sel", wb_sel, 0);
    check("t1_cnt", conflict_cnt, 0);

    // 2: four tied cycles alternate 0,1,0,1 starting from the reset priority
    do_reset();
    wb_ready = 1'b1;
    req0_addr = 5'd1; req0_data = 32'h11;
    req1_addr = 5'd2; req1_data = 32'h22;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t2_ready0", req0_ready, (k % 2 == 0));
      check("t2_ready1", req1_ready, (k % 2 == 1));
      tick();
      check("t2_wb_en", wb_en, 1);
      check("t2_wb_sel", wb_sel, k % 2);
      check("t2_wb_addr", wb_addr, (k % 2 == 0) ? 1 : 2);
    end
    check("t2_cnt", conflict_cnt, exp_cnt(4));

    // 3: stall with both valid; priority must not move
    wb_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t3_ready0", req0_ready, 0);
      check("t3_ready1", req1_ready, 0);
      check("t3_wb_en", wb_en, 1);
      check("t3_wb_addr", wb_addr, 2);
      check("t3_wb_data", wb_data, 32'h22);
      check("t3_wb_sel", wb_sel, 1);
      tick();
    end
    check("t3_cnt_stall", conflict_cnt, exp_cnt(4));
    wb_ready = 1'b1;
    #1;
    check("t3_rise_ready0", req0_ready, 1);
    check("t3_rise_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check("t3_rise_sel", wb_sel, 0);
    check("t3_rise_addr", wb_addr, 1);
    check("t3_cnt", conflict_cnt, exp_cnt(5));
    tick();
    check("t3_drain_en", wb_en, 0);
    check("t3_hold_addr", wb_addr, 1);
    check("t3_hold_sel", wb_sel, 0);

    // 4: address-0 write is accepted but dropped
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h55;
    #1;
    check("t4_ready1", req1_ready, 1);
    check("t4_ready0", req0_ready, 0);
    tick();
    req1_valid = 1'b0;
    #1;
    check("t4_zero_en", wb_en, 0);
    check("t4_zero_addr_hold", wb_addr, 1);
    check("t4_zero_data_hold", wb_data, 32'h11);
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h77;
    #1;
    check("t4_ready0", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    wb_ready = 1'b0;
    #1;
    check("t4_wb_en", wb_en, 1);
    check("t4_wb_addr", wb_addr, 7);
    check("t4_wb_data", wb_data, 32'h77);
    check("t4_cnt", conflict_cnt, exp_cnt(5));

    // 5: asynchronous reset while FULL
    tick();
    check("t5_full_before", wb_en, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_async_en", wb_en, 0);
    check("t5_async_addr", wb_addr, 0);
    check("t5_async_data", wb_data, 0);
    check("t5_async_cnt", conflict_cnt, 0);
    req0_addr = 5'd4; req0_data = 32'hA0;
    req1_addr = 5'd5; req1_data = 32'hB0;
    req0_valid = 1'b1; req1_valid = 1'b1; wb_ready = 1'b1;
    #1;
    check("t5_rst_ready0", req0_ready, 0);
    check("t5_rst_ready1", req1_ready, 0);
    tick();
    check("t5_rst_hold_en", wb_en, 0);
    #2;
    rst_n = 1'b1;
    #1;
    check("t5_first_ready0", req0_ready, 1);
    check("t5_first_ready1", req1_ready, 0);
    tick();
    check("t5_first_sel", wb_sel, 0);
    check("t5_first_addr", wb_addr, 4);
    check("t5_first_en", wb_en, 1);
    check("t5_cnt", conflict_cnt, exp_cnt(1));

    // 6: counter saturates at all-ones (CNT_W=4) and does not wrap
    for (int k = 0; k < 14; k++) tick();
    check("t6_cnt_sat", conflict_cnt, exp_cnt(15));
    for (int k = 0; k < 5; k++) tick();
    check("t6_cnt_nowrap", conflict_cnt, exp_cnt(20));
    req0_valid = 1'b0; req1_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
